// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the picorv32 native bus.
// DATA pushes into a small TX FIFO; STATUS and DIV registers sit alongside it.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd9
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        tx_busy
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] FullCount = FIFO_DEPTH[PtrW:0];

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic [15:0]     div_q;
    logic            ack_done_q;

    state_e          state_q;
    logic [7:0]      shift_q;
    logic [15:0]     bit_div_q, bit_cnt_q;
    logic [2:0]      bit_idx_q;

    logic            hit, fifo_empty, fifo_full, push_req, ack, push, pop, bit_done, line_d;
    logic [1:0]      offset;
    logic [15:0]     div_new, div_wr;
    logic [31:0]     rdata_d;
    logic            unused_bits;

    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};

    assign hit        = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign offset     = mem_addr[3:2];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullCount);
    assign push_req   = hit && (offset == 2'd0) && mem_wstrb[0];
    // ack_done_q blocks re-acknowledge until the core drops mem_valid.
    assign ack        = hit && !ack_done_q && !(push_req && fifo_full);
    assign push       = ack && push_req;
    assign pop        = (state_q == StIdle) && !fifo_empty;
    assign tx_busy    = (state_q != StIdle) || !fifo_empty;

    assign div_new = {mem_wstrb[1] ? mem_wdata[15:8] : div_q[15:8],
                      mem_wstrb[0] ? mem_wdata[7:0]  : div_q[7:0]};
    assign div_wr  = (div_new < 16'd2) ? 16'd2 : div_new;

    always_comb begin
        rdata_d = 32'd0;
        if (ack && (mem_wstrb == 4'd0)) begin
            case (offset)
                2'd1:    rdata_d = {28'd0, tx_busy, 1'b0, fifo_empty, fifo_full};
                2'd2:    rdata_d = {16'd0, div_q};
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready  <= 1'b0;
            mem_rdata  <= 32'd0;
            ack_done_q <= 1'b0;
            div_q      <= DEFAULT_DIV;
        end else begin
            mem_ready <= ack;
            mem_rdata <= rdata_d;
            if (ack) begin
                ack_done_q <= 1'b1;
            end else if (!mem_valid) begin
                ack_done_q <= 1'b0;
            end
            if (ack && (offset == 2'd2) && (mem_wstrb != 4'd0)) begin
                div_q <= div_wr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bit_done = (bit_cnt_q == bit_div_q - 16'd1);

    always_comb begin
        case (state_q)
            StStart: line_d = 1'b0;
            StData:  line_d = shift_q[0];
            default: line_d = 1'b1;
        endcase
    end

    // uart_tx trails state_q by one cycle; every bit keeps its full width.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            shift_q   <= 8'd0;
            bit_div_q <= DEFAULT_DIV;
            bit_cnt_q <= 16'd0;
            bit_idx_q <= 3'd0;
            uart_tx   <= 1'b1;
        end else begin
            uart_tx <= line_d;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        shift_q   <= fifo_mem[rd_ptr_q];
                        bit_div_q <= div_q;
                        bit_cnt_q <= 16'd0;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    if (bit_done) begin
                        bit_cnt_q <= 16'd0;
                        bit_idx_q <= 3'd0;
                        state_q   <= StData;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 16'd1;
                    end
                end
                StData: begin
                    if (bit_done) begin
                        bit_cnt_q <= 16'd0;
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_q <= StStop;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 16'd1;
                    end
                end
                StStop: begin
                    if (bit_done) begin
                        bit_cnt_q <= 16'd0;
                        state_q   <= StIdle;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: bus responses and serial frames are
// queued at issue time and checked by independent monitors.
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE = 32'h0200_0000;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
    } bus_item_t;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         chk_start;
        bit         b2b;
    } frame_t;

    logic        clk, resetn, mem_valid, mem_ready, uart_tx, tx_busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rdy_cnt = 0;
    int rdy_cyc_last = -100;
    int last_fall_cyc = -100;
    int lm_end = -100;

    bus_item_t bus_q[$];
    frame_t    line_q[$];

    uart_tx_mmio dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // Bus monitor: every mem_ready pops one expected response.
    always @(negedge clk) begin
        bus_item_t it;
        if (resetn && mem_ready) begin
            rdy_cnt++;
            rdy_cyc_last = cyc;
            if (bus_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL bus_unexpected_ready got=1 exp=0 (cyc %0d)", cyc);
            end else begin
                it = bus_q.pop_front();
                if (it.is_read) begin
                    total++;
                    if (mem_rdata !== it.data) begin
                        bad++;
                        $display("FAIL bus_rdata got=%h exp=%h (cyc %0d)", mem_rdata, it.data, cyc);
                    end
                end
            end
        end
    end

    // Line monitor: checks every cycle of each frame against the expected byte and width.
    frame_t cur;
    bit     lm_active = 0;
    bit     lm_stray = 0;
    int     lm_s, lm_err;
    always @(negedge clk) begin
        int   bp;
        logic eb;
        if (!resetn) begin
            lm_active = 0;
            line_q.delete();
        end else if (!lm_active && uart_tx === 1'b0) begin
            if (line_q.size() == 0) begin
                if (!lm_stray) begin
                    total++;
                    bad++;
                    $display("FAIL line_unexpected_start got=0 exp=1 (cyc %0d)", cyc);
                end
                lm_stray = 1;
            end else begin
                cur = line_q.pop_front();
                lm_active = 1;
                lm_s = 0;
                lm_err = 0;
                last_fall_cyc = cyc;
                if (cur.chk_start) begin
                    total++;
                    if (cyc != rdy_cyc_last + 2) begin
                        bad++;
                        $display("FAIL start_latency got=%0d exp=%0d", cyc - rdy_cyc_last, 2);
                    end
                end
                if (cur.b2b) begin
                    total++;
                    if (cyc != lm_end + 2) begin
                        bad++;
                        $display("FAIL idle_gap got=%0d exp=%0d", cyc - lm_end - 1, 1);
                    end
                end
            end
        end
        if (resetn && lm_active) begin
            bp = lm_s / cur.div;
            eb = (bp == 0) ? 1'b0 : (bp == 9) ? 1'b1 : cur.data[bp-1];
            if (uart_tx !== eb) lm_err++;
            lm_s++;
            if (lm_s == 10 * cur.div) begin
                lm_active = 0;
                lm_end = cyc;
                total++;
                if (lm_err != 0) begin
                    bad++;
                    $display("FAIL frame_%h got=%0d_bad_cycles exp=0 (div %0d)", cur.data, lm_err,
                             cur.div);
                end
            end
        end
    end

    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic [31:0] exp, output int acyc, output int rcyc);
        bus_item_t it;
        bit got;
        @(posedge clk);
        #1;
        it.is_read = (wstrb == 4'd0);
        it.data = exp;
        bus_q.push_back(it);
        mem_valid = 1'b1;
        mem_addr = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        acyc = cyc;
        rcyc = -1;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                got = 1;
                rcyc = cyc;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL bus_timeout addr=%h got=no_ready exp=ready", addr);
            bus_q.delete(bus_q.size() - 1);
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_wstrb = 4'd0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        int a, r;
        bus(addr, wdata, wstrb, 32'd0, a, r);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        int a, r;
        bus(addr, 32'd0, 4'd0, exp, a, r);
    endtask

    task automatic push_frame(input logic [7:0] d, input int div, input bit cs, input bit b2b);
        frame_t f;
        f.data = d;
        f.div = div;
        f.chk_start = cs;
        f.b2b = b2b;
        line_q.push_back(f);
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (!tx_busy && !lm_active) done = 1;
        end
        repeat (3) @(negedge clk);
        chk(name, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int a, r, f0, n0, tgt;
        bit low_seen;
        logic [7:0] bytes [5];
        bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03; bytes[3] = 8'h04; bytes[4] = 8'h05;
        resetn = 1'b0;
        mem_valid = 1'b0;
        mem_addr = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;

        bus(BASE + 4, 32'd0, 4'd0, 32'h2, a, r);
        chk("status_latency", r - a, 32'd1);
        chk("idle_line", {31'd0, uart_tx}, 32'd1);

        // A5 at 4 cycles/bit, then fill the FIFO while it is on the line.
        wr(BASE + 8, 32'd4, 4'b0011);
        push_frame(8'hA5, 4, 1, 0);
        for (int i = 0; i < 5; i++) push_frame(bytes[i], 2, 0, 1);
        wr(BASE, 32'hA5, 4'b0001);
        wr(BASE + 8, 32'd2, 4'b0011);
        for (int i = 0; i < 4; i++) wr(BASE, {24'd0, bytes[i]}, 4'b0001);
        rd(BASE + 4, 32'h9);
        f0 = last_fall_cyc;
        bus(BASE, 32'h05, 4'b0001, 32'd0, a, r);
        chk("stall_release_cyc", r - f0, 32'd41);
        wait_idle("idle_after_burst");

        // Divisor clamp and mid-frame divisor change.
        wr(BASE + 8, 32'd0, 4'b0011);
        rd(BASE + 8, 32'd2);
        wr(BASE + 8, 32'h0000_0100, 4'b0010);
        rd(BASE + 8, 32'h102);
        wr(BASE + 8, 32'd2, 4'b0011);
        push_frame(8'h3C, 2, 0, 0);
        push_frame(8'hC3, 16, 0, 1);
        wr(BASE, 32'h3C, 4'b0001);
        wr(BASE, 32'hC3, 4'b0001);
        wr(BASE + 8, 32'h10, 4'b0011);
        wait_idle("idle_after_div");

        // One hit held for three edges: a single acknowledge.
        n0 = rdy_cnt;
        @(posedge clk);
        #1;
        bus_q.push_back('{is_read: 1'b1, data: 32'h10});
        mem_valid = 1'b1;
        mem_addr = BASE + 8;
        mem_wstrb = 4'd0;
        repeat (3) @(posedge clk);
        #1 mem_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("held_valid_pulses", rdy_cnt - n0, 32'd1);

        // Out-of-window access never acknowledged.
        n0 = rdy_cnt;
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_addr = BASE + 16;
        mem_wdata = 32'hFF;
        mem_wstrb = 4'b0001;
        repeat (10) @(negedge clk);
        chk("nonhit_rdata", mem_rdata, 32'd0);
        #1 mem_valid = 1'b0;
        mem_wstrb = 4'd0;
        @(negedge clk);
        chk("nonhit_pulses", rdy_cnt - n0, 32'd0);
        chk("nonhit_line", {31'd0, uart_tx}, 32'd1);

        // Reset during data bit 3 (a 0 bit) with two bytes queued.
        wr(BASE + 8, 32'd4, 4'b0011);
        push_frame(8'h52, 4, 0, 0);
        push_frame(8'h11, 4, 0, 1);
        push_frame(8'h22, 4, 0, 1);
        wr(BASE, 32'h52, 4'b0001);
        wr(BASE, 32'h11, 4'b0001);
        wr(BASE, 32'h22, 4'b0001);
        tgt = last_fall_cyc + 18;
        for (int i = 0; i < 100 && cyc < tgt; i++) @(negedge clk);
        chk("bit3_low", {31'd0, uart_tx}, 32'd0);
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, mem_ready}, 32'd0);
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;
        rd(BASE + 4, 32'h2);
        rd(BASE + 8, 32'd9);
        low_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) low_seen = 1;
        end
        chk("no_frames_after_rst", {31'd0, low_seen}, 32'd0);

        chk("line_q_drained", line_q.size(), 32'd0);
        chk("bus_q_drained", bus_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
